// File: rtl/reduce_serial_if.sv
// Handshake bundle for reduce_serial: a vector request channel on the input
// side and a one-bit result channel on the output side, both valid/ready.
interface reduce_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic [1:0]       in_op;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic             result;

    // The reduction block itself.
    modport slave (
        input  in_valid, in_vec, in_op, out_ready,
        output in_ready, busy, out_valid, result
    );

    // The producer/consumer pair that talks to the block.
    modport master (
        output in_valid, in_vec, in_op, out_ready,
        input  in_ready, busy, out_valid, result
    );
endinterface

// File: rtl/reduce_serial.sv
// Chunked serial reduction: folds a WIDTH-bit vector to one flag, CHUNK bits
// per clock, with a run-time selectable OR / AND / XOR / NOR operation.
// The missing bits of a short last chunk are padded with the operation's
// identity so they never influence the result.
module reduce_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    reduce_serial_if.slave bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int IDX_W  = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_vec;
    op_e              r_op;
    logic             r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_result;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic             w_ident;
    logic [PADW-1:0]  w_padded;
    logic [CHUNK-1:0] w_chunk;
    logic             w_fold;
    logic             w_acc_next;
    op_e              w_in_op;

    assign w_in_op  = op_e'(bus.in_op);
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state is updated with <= so every register samples
        // pre-edge values regardless of the order the blocks are evaluated in.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs, all driven purely from state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Select the current chunk (identity-padded past bit WIDTH-1) and fold it.
    always_comb begin
        w_ident                = (r_op == OP_AND);
        w_padded               = {PADW{w_ident}};
        w_padded[WIDTH-1:0]    = r_vec;
        w_chunk                = {CHUNK{w_ident}};
        if (r_idx < IDX_W'(NCHUNK)) begin
            w_chunk = w_padded[r_idx * CHUNK +: CHUNK];
        end
        w_fold     = 1'b0;
        w_acc_next = r_acc;
        case (r_op)
            OP_AND: begin
                w_fold     = &w_chunk;
                w_acc_next = r_acc & w_fold;
            end
            OP_XOR: begin
                w_fold     = ^w_chunk;
                w_acc_next = r_acc ^ w_fold;
            end
            default: begin
                // NOR accumulates as OR; the inversion is applied once at the end.
                w_fold     = |w_chunk;
                w_acc_next = r_acc | w_fold;
            end
        endcase
    end

    // Capture the request in IDLE, accumulate chunk by chunk in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_op     <= OP_OR;
            r_acc    <= 1'b0;
            r_idx    <= '0;
            r_result <= 1'b0;
        end else if (w_accept) begin
            r_vec <= bus.in_vec;
            r_op  <= w_in_op;
            r_acc <= (w_in_op == OP_AND);
            r_idx <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_result <= (r_op == OP_NOR) ? ~w_acc_next : w_acc_next;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
endmodule

// File: tb/tb_reduce_serial.sv
// Directed bench for reduce_serial with WIDTH=8, CHUNK=3 (three BUSY cycles,
// last chunk padded by one bit). Expected flags come from a whole-vector
// reference model and are queued at accept time, then checked when
// out_valid rises together with the accept-to-valid latency.
module tb_reduce_serial;
    localparam int WIDTH = 8;
    localparam int CHUNK = 3;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    logic clk;
    logic rst_n;

    reduce_serial_if #(.WIDTH(WIDTH)) bus ();

    reduce_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    logic exp_q[$];
    int   acc_q[$];
    logic prev_ov  = 1'b0;
    bit   b2b_on   = 1'b0;
    int   last_acc = -1;
    int   b2b_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic model(input logic [1:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_OR:   return |v;
            OP_AND:  return &v;
            OP_XOR:  return ^v;
            default: return ~|v;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; score a result when out_valid rises.
    task automatic tick();
        logic e;
        int   a;
        @(negedge clk);
        if (bus.out_valid && !prev_ov) begin
            check("result_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("result", bus.result, e);
                check("latency", cyc - a, 4);
            end
        end
        prev_ov = bus.out_valid;
    endtask

    // Drive inputs for the coming rising edge; queue an expectation on accept.
    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] vec, input logic ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_vec    = vec;
        bus.out_ready = ordy;
        if (bus.in_ready && v) begin
            exp_q.push_back(model(op, vec));
            acc_q.push_back(cyc);
            if (b2b_on) begin
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 5);
                last_acc = cyc;
                b2b_cnt++;
            end
        end
    endtask

    task automatic wait_result();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("result_timeout", exp_q.size(), 0);
    endtask

    task automatic run(input logic [1:0] op, input logic [WIDTH-1:0] vec);
        tick();
        check("accept_ready", bus.in_ready, 1);
        drive(1'b1, op, vec, 1'b1);
        tick();
        drive(1'b0, op, vec, 1'b1);
        wait_result();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset values.
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // OR: all-zero, then only the bit that lives in the padded chunk.
        run(OP_OR, 8'h00);
        run(OP_OR, 8'h80);
        // AND: the pad bit must act as 1.
        run(OP_AND, 8'hFF);
        run(OP_AND, 8'hBF);
        // XOR parity and NOR inversion.
        run(OP_XOR, 8'hA7);
        run(OP_NOR, 8'h00);
        run(OP_NOR, 8'h40);
        run(OP_XOR, 8'hC0);

        // Inputs toggled during BUSY are ignored; DONE holds while out_ready=0.
        tick();
        drive(1'b1, OP_AND, 8'hFF, 1'b0);
        tick();
        check("busy_high", bus.busy, 1);
        drive(1'b1, OP_OR, 8'h00, 1'b0);
        tick();
        drive(1'b1, OP_XOR, 8'h01, 1'b0);
        tick();
        drive(1'b0, OP_OR, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_result", bus.result, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        drive(1'b0, OP_OR, 8'h00, 1'b1);
        tick();
        check("release_out_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);

        // Back-to-back traffic with out_ready tied high.
        b2b_on   = 1'b1;
        last_acc = -1;
        b2b_cnt  = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
            tick();
        end
        drive(1'b0, OP_OR, 8'h00, 1'b1);
        b2b_on = 1'b0;
        check("b2b_accepts", b2b_cnt, 6);
        wait_result();

        // Leave result=1, then abort an operation during its 2nd BUSY cycle.
        run(OP_XOR, 8'hA7);
        tick();
        drive(1'b1, OP_AND, 8'h00, 1'b1);
        tick();
        drive(1'b0, OP_OR, 8'h00, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.result, 0);
        exp_q.delete();
        acc_q.delete();
        prev_ov = 1'b0;
        tick();
        rst_n = 1'b1;
        run(OP_OR, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
